// File: rtl/serial_frame_tx_1011.sv
// serial_frame_tx_1011: serial framer emitting sync word, MSB-first payload and optional parity, one bit per clock.
// Optional trailing even-parity bit is enabled by defining SERIAL_FRAME_PARITY_EN.
module serial_frame_tx_1011 #(
    parameter int DATA_W = 8,
    parameter int SYNC_LEN = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1011
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              frame_done
);
    localparam int MAX_W = SYNC_LEN > DATA_W ? SYNC_LEN : DATA_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;
`ifdef SERIAL_FRAME_PARITY_EN
    localparam bit LAST_DATA = 1'b0;
    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;
`else
    localparam bit LAST_DATA = 1'b1;
    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [SYNC_LEN-1:0] sync_sr, sync_n;
    logic dout_n, valid_n, done_n, accept;
`ifdef SERIAL_FRAME_PARITY_EN
    logic par, par_n;
`endif

    // A new word may start in the last-bit cycle, giving gapless back-to-back frames.
    assign data_ready = (state == IDLE) || frame_done;
    assign accept = data_valid && data_ready;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            shreg <= '0;
            sync_sr <= '0;
            dout <= 1'b0;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            shreg <= shreg_n;
            sync_sr <= sync_n;
            dout <= dout_n;
            dout_valid <= valid_n;
            frame_done <= done_n;
`ifdef SERIAL_FRAME_PARITY_EN
            par <= par_n;
`endif
        end
    end

    // cnt holds the number of bits of the current state still to follow the one on dout.
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        shreg_n = shreg;
        sync_n = sync_sr;
        dout_n = 1'b0;
        valid_n = 1'b0;
        done_n = 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
        par_n = par;
`endif
        if (accept) begin
            state_n = SYNC;
            cnt_n = CNT_W'(SYNC_LEN - 1);
            shreg_n = data_in;
            sync_n = SYNC_PATTERN << 1;
            dout_n = SYNC_PATTERN[SYNC_LEN-1];
            valid_n = 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
            par_n = ^data_in;
`endif
        end else begin
            case (state)
                SYNC: begin
                    valid_n = 1'b1;
                    if (cnt != '0) begin
                        cnt_n = cnt - 1'b1;
                        dout_n = sync_sr[SYNC_LEN-1];
                        sync_n = sync_sr << 1;
                    end else begin
                        state_n = DATA;
                        cnt_n = CNT_W'(DATA_W - 1);
                        dout_n = shreg[DATA_W-1];
                        shreg_n = shreg << 1;
                        done_n = LAST_DATA && (DATA_W == 1);
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        valid_n = 1'b1;
                        cnt_n = cnt - 1'b1;
                        dout_n = shreg[DATA_W-1];
                        shreg_n = shreg << 1;
                        done_n = LAST_DATA && (cnt == CNT_W'(1));
                    end else begin
`ifdef SERIAL_FRAME_PARITY_EN
                        state_n = PARITY;
                        valid_n = 1'b1;
                        dout_n = par;
                        done_n = 1'b1;
`else
                        state_n = IDLE;
`endif
                    end
                end
`ifdef SERIAL_FRAME_PARITY_EN
                PARITY: state_n = IDLE;
`endif
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_tx_1011.sv
// tb_serial_frame_tx_1011: directed table vectors, back-to-back, ignored-valid, mid-frame reset and random frames.
module tb_serial_frame_tx_1011;
`ifdef SERIAL_FRAME_PARITY_EN
    localparam int FL = 13;
`else
    localparam int FL = 12;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] data_in = '0;
    logic data_valid = 1'b0;
    logic data_ready, dout, dout_valid, busy, frame_done;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] d;
        logic [11:0] f;
        logic p;
    } vec_t;
    vec_t vecs[8];

    serial_frame_tx_1011 dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .dout(dout), .dout_valid(dout_valid),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] exp_of(input vec_t v);
`ifdef SERIAL_FRAME_PARITY_EN
        return {v.f, v.p};
`else
        return {1'b0, v.f};
`endif
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, " idle dout"}, 32'(dout), 0);
        chk({tag, " idle dout_valid"}, 32'(dout_valid), 0);
        chk({tag, " idle busy"}, 32'(busy), 0);
        chk({tag, " idle frame_done"}, 32'(frame_done), 0);
        chk({tag, " idle data_ready"}, 32'(data_ready), 1);
    endtask

    // Offers d from idle; returns at the falling edge where the first frame bit is on the line.
    task automatic start(input logic [7:0] d);
        int k = 0;
        data_in = d;
        data_valid = 1'b1;
        while (!data_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("start %02h ready", d), 32'(data_ready), 1);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic check_bits(input logic [12:0] exp, input bit nxt_en, input logic [7:0] nxt_d,
                              input int pulse_at, input logic [7:0] pulse_d, input string tag);
        for (int i = 0; i < FL; i++) begin
            if (nxt_en) begin
                data_in = nxt_d;
                data_valid = 1'b1;
            end else begin
                data_valid = (i == pulse_at);
                if (i == pulse_at) data_in = pulse_d;
            end
            chk($sformatf("%s bit%0d dout", tag, i), 32'(dout), 32'(exp[FL-1-i]));
            chk($sformatf("%s bit%0d dout_valid", tag, i), 32'(dout_valid), 1);
            chk($sformatf("%s bit%0d busy", tag, i), 32'(busy), 1);
            chk($sformatf("%s bit%0d frame_done", tag, i), 32'(frame_done), 32'(i == FL - 1));
            chk($sformatf("%s bit%0d data_ready", tag, i), 32'(data_ready), 32'(i == FL - 1));
            if (i < FL - 1) @(negedge clk);
        end
        @(negedge clk);
        data_valid = 1'b0;
        if (!nxt_en) chk_idle(tag);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 12'b1011_10100101, 1'b0};
        vecs[1] = '{8'h0F, 12'b1011_00001111, 1'b0};
        vecs[2] = '{8'hF0, 12'b1011_11110000, 1'b0};
        vecs[3] = '{8'h81, 12'b1011_10000001, 1'b0};
        vecs[4] = '{8'hFF, 12'b1011_11111111, 1'b0};
        vecs[5] = '{8'h3C, 12'b1011_00111100, 1'b0};
        vecs[6] = '{8'h07, 12'b1011_00000111, 1'b1};
        vecs[7] = '{8'h03, 12'b1011_00000011, 1'b0};

        #12;
        chk("reset dout", 32'(dout), 0);
        chk("reset dout_valid", 32'(dout_valid), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset frame_done", 32'(frame_done), 0);
        @(negedge clk);
        reset = 1'b0;
        chk_idle("post-reset");

        for (int v = 0; v < 8; v++) begin
            start(vecs[v].d);
            check_bits(exp_of(vecs[v]), 1'b0, 8'h00, -1, 8'h00, $sformatf("vec%0d", v));
        end

        // data_valid held high across two words: gapless frames, second word waits for the last-bit window.
        start(8'h0F);
        check_bits(exp_of(vecs[1]), 1'b1, 8'hF0, -1, 8'h00, "b2b first");
        check_bits(exp_of(vecs[2]), 1'b0, 8'h00, -1, 8'h00, "b2b second");

        // A one-cycle valid pulse mid-frame is ignored and not sent later.
        start(8'hA5);
        check_bits(exp_of(vecs[0]), 1'b0, 8'h00, 4, 8'h3C, "pulse");
        repeat (3) @(negedge clk);
        chk("pulse no late frame", 32'(dout_valid), 0);

        // Asynchronous reset six bits into a frame.
        start(8'hFF);
        repeat (5) @(negedge clk);
        chk("pre-abort dout_valid", 32'(dout_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("abort dout", 32'(dout), 0);
        chk("abort dout_valid", 32'(dout_valid), 0);
        chk("abort busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        chk_idle("after abort");
        start(8'h81);
        check_bits(exp_of(vecs[3]), 1'b0, 8'h00, -1, 8'h00, "after abort frame");

        for (int n = 0; n < 1000; n++) begin
            vec_t r;
            int g;
            r.d = 8'($urandom);
            r.f = {4'b1011, r.d};
            r.p = ^r.d;
            start(r.d);
            check_bits(exp_of(r), 1'b0, 8'h00, -1, 8'h00, $sformatf("rnd%0d", n));
            g = $urandom_range(0, 3);
            repeat (g) begin
                @(negedge clk);
                chk($sformatf("rnd%0d gap dout_valid", n), 32'(dout_valid), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
